// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SHIFT,
      DONE
   } ccff_state_e;

   localparam logic MODE_LOAD   = 1'b0;
   localparam logic MODE_VERIFY = 1'b1;

endpackage

// File: rtl/ccff_byte_serializer.sv
// Parallel-load byte shift register, MSB out first, with a 3-bit shift counter.
module ccff_byte_serializer (
   input  logic       clk,
   input  logic       srst,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] data,
   output logic       bit_out,
   output logic       empty
);

   logic [7:0] shreg_reg;
   logic [2:0] bit_cnt_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         shreg_reg   <= 8'd0;
         bit_cnt_reg <= 3'd0;
      end else if (load) begin
         shreg_reg   <= data;
         bit_cnt_reg <= 3'd0;
      end else if (shift) begin
         shreg_reg   <= {shreg_reg[6:0], 1'b0};
         bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
   end

   assign bit_out = shreg_reg[7];
   // High while the last bit of the byte is on bit_out; the byte is exhausted after this shift.
   assign empty   = (bit_cnt_reg == 3'd7);

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams configuration bytes MSB-first into the ccff chain; optionally verifies the
// returning tail bits against the re-shifted bitstream.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter  int CHAIN_LEN = 36,
   localparam int IDX_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic             prog_clk,
   input  logic             prog_reset,
   input  logic             start,
   input  logic             mode,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             ccff_head,
   output logic             ccff_shift_en,
   input  logic             ccff_tail,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDX_W-1:0] err_idx
);

   ccff_state_e      state_reg, state_next;
   logic             mode_reg;
   logic [IDX_W-1:0] cnt_reg;
   logic             err_reg;
   logic [IDX_W-1:0] err_idx_reg;

   logic ser_load, ser_shift, ser_bit, ser_empty;
   logic last_bit;

   ccff_byte_serializer u_ser (
      .clk     (prog_clk),
      .srst    (prog_reset),
      .load    (ser_load),
      .shift   (ser_shift),
      .data    (s_data),
      .bit_out (ser_bit),
      .empty   (ser_empty)
   );

   assign last_bit = (cnt_reg == IDX_W'(CHAIN_LEN - 1));

   always_comb begin
      state_next    = state_reg;
      s_ready       = 1'b0;
      ccff_head     = 1'b0;
      ccff_shift_en = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      ser_load      = 1'b0;
      ser_shift     = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = FETCH;
         end
         FETCH: begin
            s_ready  = 1'b1;
            ser_load = s_valid;
            if (s_valid) state_next = SHIFT;
         end
         SHIFT: begin
            ccff_head     = ser_bit;
            ccff_shift_en = 1'b1;
            ser_shift     = 1'b1;
            // Chain end wins over byte end: leftover bits of the final byte are padding.
            if (last_bit)       state_next = DONE;
            else if (ser_empty) state_next = FETCH;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_reg   <= IDLE;
         mode_reg    <= MODE_LOAD;
         cnt_reg     <= '0;
         err_reg     <= 1'b0;
         err_idx_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && start) begin
            mode_reg    <= mode;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            err_idx_reg <= '0;
         end
         if (state_reg == SHIFT) begin
            cnt_reg <= cnt_reg + IDX_W'(1);
            // Only the first mismatch is recorded; err stays set until the next start.
            if (mode_reg == MODE_VERIFY && ccff_tail != ser_bit && !err_reg) begin
               err_reg     <= 1'b1;
               err_idx_reg <= cnt_reg;
            end
         end
      end
   end

   assign err     = err_reg;
   assign err_idx = err_idx_reg;

endmodule
